// File: rtl/ddr_port0_pixel_writer.sv
// Write-side DDR port 0 controller: packs raster pixels into MIG write bursts of up to
// BURST_WORDS words, commands each burst and waits for the MIG to drain it.
`timescale 1ns/1ps

module ddr_port0_pixel_writer #(
    parameter int unsigned BURST_WORDS = 64,
    parameter logic [29:0] BASE_ADDR   = 30'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic [20:0] total_pixels,
    input  logic [31:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        wr_full,
    input  logic        wr_empty,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    output logic        frame_done,
    output logic [20:0] pointer
);

    typedef enum logic [1:0] {
        CAL,
        FILL,
        CMD,
        DRAIN
    } state_t;

    localparam logic [6:0]  BURST_LEN_MAX = 7'(BURST_WORDS);
    localparam logic [20:0] BURST_WIDE    = 21'(BURST_WORDS);

    state_t      state;
    logic        calib_meta;
    logic        calib_sync;
    logic [20:0] frame_px;
    logic [20:0] burst_base;
    logic [20:0] remaining;
    logic [20:0] burst_end;
    logic [6:0]  burst_cnt;
    logic [6:0]  burst_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            calib_meta <= mem_calib_done;
            calib_sync <= calib_meta;
        end
    end

    // Final burst of a frame is truncated to whatever pixels remain.
    always_comb begin
        remaining = frame_px - burst_base;
        burst_len = (remaining >= BURST_WIDE) ? BURST_LEN_MAX : remaining[6:0];
        burst_end = burst_base + 21'(burst_len);
    end

    assign pix_ready = (state == FILL) && !wr_full && (burst_cnt < burst_len);
    assign wr_en     = pix_valid && pix_ready;
    assign wr_data   = pix_data;
    assign wr_mask   = '0;
    assign cmd_instr = 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= CAL;
            frame_px      <= '0;
            burst_base    <= '0;
            burst_cnt     <= '0;
            pointer       <= '0;
            cmd_en        <= 1'b0;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
            frame_done    <= 1'b0;
        end else begin
            cmd_en     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                CAL: begin
                    if (calib_sync) begin
                        frame_px   <= total_pixels;
                        burst_base <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (burst_cnt == burst_len) begin
                        state <= CMD;
                    end else if (wr_en) begin
                        burst_cnt <= burst_cnt + 7'd1;
                        pointer   <= pointer + 21'd1;
                    end
                end
                CMD: begin
                    if (!cmd_full) begin
                        cmd_en        <= 1'b1;
                        cmd_bl        <= 6'(burst_len - 7'd1);
                        cmd_byte_addr <= BASE_ADDR + {7'd0, burst_base, 2'b00};
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_empty) begin
                        burst_cnt <= '0;
                        state     <= FILL;
                        if (burst_end == frame_px) begin
                            frame_done <= 1'b1;
                            pointer    <= '0;
                            burst_base <= '0;
                            frame_px   <= total_pixels;
                        end else begin
                            burst_base <= burst_end;
                        end
                    end
                end
                default: state <= CAL;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_port0_pixel_writer.sv
// Scoreboard bench for ddr_port0_pixel_writer: expected write words, commands and frame
// completions are queued by the stimulus and checked by a monitor alongside a small MIG model.
`timescale 1ns/1ps

module tb_ddr_port0_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_calib_done;
    logic [20:0] total_pixels;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        wr_full;
    logic        wr_empty = 1'b1;
    logic        cmd_full;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        frame_done;
    logic [20:0] pointer;

    ddr_port0_pixel_writer #(
        .BURST_WORDS(64),
        .BASE_ADDR  (30'd0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_calib_done(mem_calib_done),
        .total_pixels  (total_pixels),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .wr_full       (wr_full),
        .wr_empty      (wr_empty),
        .cmd_full      (cmd_full),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .frame_done    (frame_done),
        .pointer       (pointer)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] src_q[$];
    logic [31:0] exp_wr[$];
    logic [35:0] exp_cmd[$];
    int          exp_frames = 0;
    int          got_frames = 0;
    int          cmd_seen = 0;
    int          fifo_cnt = 0;
    int          drain_t = 0;
    bit          src_en = 1'b0;
    logic        acc;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor plus MIG model: FIFO empties a few cycles after each command.
    always @(negedge clk) begin
        if (reset) begin
            fifo_cnt = 0;
            drain_t  = 0;
            wr_empty = 1'b1;
        end else begin
            if (wr_en) begin
                chk("wr_en_while_full", 64'(wr_full), 64'd0);
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_wr: got data %0h expected no write", wr_data);
                end else begin
                    chk("wr_data", 64'(wr_data), 64'(exp_wr.pop_front()));
                end
                fifo_cnt++;
            end
            if (cmd_en) begin
                cmd_seen++;
                if (exp_cmd.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cmd: got addr %0h bl %0d expected no command",
                             cmd_byte_addr, cmd_bl);
                end else begin
                    logic [35:0] e;
                    e = exp_cmd.pop_front();
                    chk("cmd_byte_addr", 64'(cmd_byte_addr), 64'(e[29:0]));
                    chk("cmd_bl", 64'(cmd_bl), 64'(e[35:30]));
                    chk("cmd_instr", 64'(cmd_instr), 64'd0);
                    chk("wr_mask", 64'(wr_mask), 64'd0);
                end
                drain_t = 6;
            end else if (drain_t > 0) begin
                drain_t--;
                if (drain_t == 0) fifo_cnt = 0;
            end
            if (frame_done) begin
                got_frames++;
                chk("pointer_at_frame_done", 64'(pointer), 64'd0);
            end
            wr_empty = (fifo_cnt == 0);
        end
    end

    // Pixel source: offers the head of src_q, pops it once accepted.
    always begin
        @(negedge clk);
        acc = pix_valid && pix_ready;
        @(posedge clk);
        #1;
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        pix_valid = src_en && (src_q.size() > 0);
        pix_data  = (src_q.size() > 0) ? src_q[0] : '0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_frame(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(base + 32'(i));
            exp_wr.push_back(base + 32'(i));
        end
    endtask

    task automatic push_cmd(input logic [29:0] addr, input logic [5:0] bl);
        exp_cmd.push_back({bl, addr});
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((exp_wr.size() != 0 || exp_cmd.size() != 0 || got_frames != exp_frames) &&
               k < budget) begin
            tick();
            k++;
        end
        chk({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        chk({name, "_cmd_left"}, 64'(exp_cmd.size()), 64'd0);
        chk({name, "_frames"}, 64'(got_frames), 64'(exp_frames));
    endtask

    task automatic wait_ptr(input string name, input logic [20:0] target, input int budget);
        int k = 0;
        while (pointer != target && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(pointer), 64'(target));
    endtask

    initial begin
        int c0;
        reset          = 1'b1;
        mem_calib_done = 1'b0;
        total_pixels   = 21'd128;
        wr_full        = 1'b0;
        cmd_full       = 1'b0;
        pix_valid      = 1'b0;
        pix_data       = '0;
        repeat (3) tick();
        chk("rst_pix_ready", 64'(pix_ready), 64'd0);
        chk("rst_cmd_en", 64'(cmd_en), 64'd0);
        chk("rst_cmd_bl", 64'(cmd_bl), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_byte_addr), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_pointer", 64'(pointer), 64'd0);
        reset = 1'b0;

        // Pixels offered while calibration is still pending must not be taken.
        load_frame(128, 32'hA000_0000);
        push_cmd(30'd0, 6'd63);
        push_cmd(30'd256, 6'd63);
        exp_frames++;
        src_en = 1'b1;
        repeat (100) begin
            tick();
            chk("cal_pix_ready", 64'(pix_ready), 64'd0);
            chk("cal_wr_en", 64'(wr_en), 64'd0);
            chk("cal_cmd_en", 64'(cmd_en), 64'd0);
        end
        mem_calib_done = 1'b1;
        repeat (10) tick();
        total_pixels = 21'd100;
        wait_done("frame128", 3000);

        load_frame(100, 32'hB000_0000);
        push_cmd(30'd0, 6'd63);
        push_cmd(30'd256, 6'd35);
        exp_frames++;
        wait_done("frame100", 3000);

        // Write FIFO full mid-burst.
        load_frame(100, 32'hC000_0000);
        push_cmd(30'd0, 6'd63);
        push_cmd(30'd256, 6'd35);
        exp_frames++;
        wait_ptr("wrfull_ptr10", 21'd10, 500);
        wr_full = 1'b1;
        repeat (20) begin
            tick();
            chk("wrfull_pix_ready", 64'(pix_ready), 64'd0);
            chk("wrfull_pointer", 64'(pointer), 64'd10);
        end
        wr_full = 1'b0;
        wait_done("wrfull", 3000);

        // Command FIFO full when the first burst completes.
        cmd_full = 1'b1;
        load_frame(100, 32'hD000_0000);
        push_cmd(30'd0, 6'd63);
        push_cmd(30'd256, 6'd35);
        exp_frames++;
        wait_ptr("cmdfull_ptr64", 21'd64, 500);
        c0 = cmd_seen;
        repeat (20) tick();
        chk("cmdfull_no_cmd", 64'(cmd_seen), 64'(c0));
        chk("cmdfull_pointer", 64'(pointer), 64'd64);
        cmd_full = 1'b0;
        wait_done("cmdfull", 3000);

        // Reset in the middle of a burst.
        load_frame(100, 32'hE000_0000);
        wait_ptr("rstmid_ptr37", 21'd37, 500);
        reset = 1'b1;
        #1;
        chk("rstmid_pix_ready", 64'(pix_ready), 64'd0);
        chk("rstmid_wr_en", 64'(wr_en), 64'd0);
        chk("rstmid_cmd_en", 64'(cmd_en), 64'd0);
        chk("rstmid_pointer", 64'(pointer), 64'd0);
        chk("rstmid_cmd_addr", 64'(cmd_byte_addr), 64'd0);
        src_en = 1'b0;
        src_q.delete();
        exp_wr.delete();
        exp_cmd.delete();
        mem_calib_done = 1'b0;
        total_pixels   = 21'd64;
        repeat (5) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("postrst_pix_ready", 64'(pix_ready), 64'd0);
        load_frame(64, 32'hF000_0000);
        push_cmd(30'd0, 6'd63);
        exp_frames++;
        src_en = 1'b1;
        mem_calib_done = 1'b1;
        wait_done("postrst", 3000);

        repeat (10) tick();
        chk("final_frames", 64'(got_frames), 64'(exp_frames));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
